// File: rtl/bcd_timekeeper_pkg.sv
// Shared BCD constants and helpers for the time-of-day counter.
// Packed-BCD values compare correctly as binary once both nibbles are legal digits.
package bcd_timekeeper_pkg;

    localparam logic [7:0] Bcd00 = 8'h00;
    localparam logic [7:0] Bcd01 = 8'h01;
    localparam logic [7:0] Bcd11 = 8'h11;
    localparam logic [7:0] Bcd12 = 8'h12;
    localparam logic [7:0] Bcd23 = 8'h23;
    localparam logic [7:0] Bcd59 = 8'h59;

    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_timekeeper_counter.sv
// Two-digit packed-BCD modulo counter: counts up to MaxVal then wraps to MinVal.
// Load has priority over increment.
module bcd_mod_counter
    import bcd_timekeeper_pkg::*;
#(
    parameter logic [7:0] MaxVal = Bcd59,
    parameter logic [7:0] MinVal = Bcd00,
    parameter logic [7:0] RstVal = Bcd00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] val_o,
    output logic [7:0] next_o,
    output logic       carry_o
);

    logic [7:0] val_q, val_d;

    assign next_o  = (val_q == MaxVal) ? MinVal : bcd_inc(val_q);
    assign carry_o = inc_i && (val_q == MaxVal);
    assign val_o   = val_q;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i) begin
            val_d = next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= RstVal;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day clock with prescaler, validated time load and hh:mm alarm.
// 24-hour or 12-hour (AM/PM) counting selected at elaboration.
module bcd_timekeeper
    import bcd_timekeeper_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned MODE12  = 0,
    parameter logic [7:0]  RST_HH  = 8'h23,
    parameter logic [7:0]  RST_MM  = 8'h59,
    parameter logic [7:0]  RST_SS  = 8'h45,
    parameter logic        RST_PM  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic       load_i,
    input  logic [7:0] load_hh_i,
    input  logic [7:0] load_mm_i,
    input  logic [7:0] load_ss_i,
    input  logic       load_pm_i,
    input  logic       alm_wr_i,
    input  logic [7:0] alm_hh_i,
    input  logic [7:0] alm_mm_i,
    input  logic       alm_pm_i,
    input  logic       alm_en_i,
    output logic [7:0] hh_o,
    output logic [7:0] mm_o,
    output logic [7:0] ss_o,
    output logic       pm_o,
    output logic       tick_o,
    output logic       alarm_o,
    output logic       load_err_o
);

    localparam bit          Is12     = (MODE12 != 0);
    localparam logic [7:0]  HhMax    = Is12 ? Bcd12 : Bcd23;
    localparam logic [7:0]  HhMin    = Is12 ? Bcd01 : Bcd00;
    localparam int unsigned PrescW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_DIV - 1);
    localparam logic        RstPm    = Is12 ? RST_PM : 1'b0;

    if (CLK_DIV < 1 || !bcd_in_range(RST_HH, HhMin, HhMax) ||
        !bcd_in_range(RST_MM, Bcd00, Bcd59) || !bcd_in_range(RST_SS, Bcd00, Bcd59)) begin : g_bad_param
        $error("bcd_timekeeper: illegal CLK_DIV or reset time for this mode");
    end

    logic [PrescW-1:0] presc_q, presc_d;
    logic              pm_q, pm_d;
    logic [7:0]        alm_hh_q, alm_mm_q;
    logic              alm_pm_q;
    logic              alarm_q, load_err_q;

    logic       load_ok, tick, alm_match;
    logic [7:0] hh_q, mm_q, ss_q, hh_next, mm_next, hh_after;
    logic       ss_carry, mm_carry;
    logic       unused_hh_carry;
    logic [7:0] unused_ss_next;

    assign load_ok = load_i && bcd_in_range(load_hh_i, HhMin, HhMax) &&
                     bcd_in_range(load_mm_i, Bcd00, Bcd59) && bcd_in_range(load_ss_i, Bcd00, Bcd59);
    // Any load request, legal or not, freezes the prescaler and swallows the tick.
    assign tick    = ena_i && !load_i && (presc_q == PrescMax);

    bcd_mod_counter #(.MaxVal(Bcd59), .MinVal(Bcd00), .RstVal(RST_SS)) u_ss (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(tick), .load_i(load_ok), .load_val_i(load_ss_i),
        .val_o(ss_q), .next_o(unused_ss_next), .carry_o(ss_carry)
    );

    bcd_mod_counter #(.MaxVal(Bcd59), .MinVal(Bcd00), .RstVal(RST_MM)) u_mm (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(ss_carry), .load_i(load_ok),
        .load_val_i(load_mm_i), .val_o(mm_q), .next_o(mm_next), .carry_o(mm_carry)
    );

    bcd_mod_counter #(.MaxVal(HhMax), .MinVal(HhMin), .RstVal(RST_HH)) u_hh (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(mm_carry), .load_i(load_ok),
        .load_val_i(load_hh_i), .val_o(hh_q), .next_o(hh_next), .carry_o(unused_hh_carry)
    );

    always_comb begin
        presc_d = presc_q;
        if (load_ok) begin
            presc_d = '0;
        end else if (!load_i && ena_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        pm_d = pm_q;
        if (load_ok) begin
            pm_d = Is12 && load_pm_i;
        end else if (Is12 && mm_carry && (hh_q == Bcd11)) begin
            pm_d = ~pm_q;
        end
    end

    // Compare the time this tick will produce against the alarm registers as they
    // stand now, so a coincident alm_wr does not affect the match.
    assign hh_after  = (mm_q == Bcd59) ? hh_next : hh_q;
    assign alm_match = (ss_q == Bcd59) && (mm_next == alm_mm_q) && (hh_after == alm_hh_q) &&
                       (!Is12 || (pm_d == alm_pm_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            pm_q       <= RstPm;
            alm_hh_q   <= Bcd00;
            alm_mm_q   <= Bcd00;
            alm_pm_q   <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pm_q       <= pm_d;
            alarm_q    <= tick && alm_en_i && alm_match;
            load_err_q <= load_i && !load_ok;
            if (alm_wr_i) begin
                alm_hh_q <= alm_hh_i;
                alm_mm_q <= alm_mm_i;
                alm_pm_q <= alm_pm_i;
            end
        end
    end

    assign hh_o       = hh_q;
    assign mm_o       = mm_q;
    assign ss_o       = ss_q;
    assign pm_o       = pm_q;
    assign tick_o     = tick && rst_ni;
    assign alarm_o    = alarm_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench: a 24-hour instance (CLK_DIV=4) and a 12-hour instance (CLK_DIV=1).
// Expected times come from a seconds-of-day model pushed into a scoreboard queue.
module tb_bcd_timekeeper;

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic       pm;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_ena, a_load, a_lpm, a_alm_wr, a_alm_pm, a_alm_en;
    logic [7:0] a_lhh, a_lmm, a_lss, a_alm_hh, a_alm_mm;
    logic [7:0] a_hh, a_mm, a_ss;
    logic       a_pm, a_tick, a_alarm, a_err;

    logic       b_ena, b_load, b_lpm, b_alm_wr, b_alm_pm, b_alm_en;
    logic [7:0] b_lhh, b_lmm, b_lss, b_alm_hh, b_alm_mm;
    logic [7:0] b_hh, b_mm, b_ss;
    logic       b_pm, b_tick, b_alarm, b_err;

    bcd_timekeeper #(.CLK_DIV(4), .MODE12(0)) u_dut24 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(a_ena), .load_i(a_load),
        .load_hh_i(a_lhh), .load_mm_i(a_lmm), .load_ss_i(a_lss), .load_pm_i(a_lpm),
        .alm_wr_i(a_alm_wr), .alm_hh_i(a_alm_hh), .alm_mm_i(a_alm_mm), .alm_pm_i(a_alm_pm),
        .alm_en_i(a_alm_en), .hh_o(a_hh), .mm_o(a_mm), .ss_o(a_ss), .pm_o(a_pm),
        .tick_o(a_tick), .alarm_o(a_alarm), .load_err_o(a_err)
    );

    bcd_timekeeper #(.CLK_DIV(1), .MODE12(1), .RST_HH(8'h11), .RST_MM(8'h59), .RST_SS(8'h45),
                     .RST_PM(1'b1)) u_dut12 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(b_ena), .load_i(b_load),
        .load_hh_i(b_lhh), .load_mm_i(b_lmm), .load_ss_i(b_lss), .load_pm_i(b_lpm),
        .alm_wr_i(b_alm_wr), .alm_hh_i(b_alm_hh), .alm_mm_i(b_alm_mm), .alm_pm_i(b_alm_pm),
        .alm_en_i(b_alm_en), .hh_o(b_hh), .mm_o(b_mm), .ss_o(b_ss), .pm_o(b_pm),
        .tick_o(b_tick), .alarm_o(b_alarm), .load_err_o(b_err)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vt[9];
    int   a_cur, b_cur, first_k;
    exp_t e;

    function automatic int bcd2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int to_sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                  input logic pm, input bit m12);
        int hr = bcd2i(h);
        if (m12) hr = (hr == 12 ? 0 : hr) + (pm ? 12 : 0);
        return hr * 3600 + bcd2i(m) * 60 + bcd2i(s);
    endfunction

    function automatic exp_t from_sec(input int t, input bit m12);
        exp_t r;
        int   hr = t / 3600;
        r.mm  = i2bcd((t / 60) % 60);
        r.ss  = i2bcd(t % 60);
        r.pm  = 1'b0;
        r.err = 1'b0;
        if (m12) begin
            r.pm = (hr >= 12);
            hr   = hr % 12;
            if (hr == 0) hr = 12;
        end
        r.hh = i2bcd(hr);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss, input logic pm, input logic err);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            x = sb.pop_front();
            chk({name, ".hh"}, 32'(hh), 32'(x.hh));
            chk({name, ".mm"}, 32'(mm), 32'(x.mm));
            chk({name, ".ss"}, 32'(ss), 32'(x.ss));
            chk({name, ".pm"}, 32'(pm), 32'(x.pm));
            chk({name, ".err"}, 32'(err), 32'(x.err));
        end
    endtask

    // Load on the 12-hour instance with ena high: the load must win over the tick.
    task automatic b_do_load(input string name, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input logic pm, input logic err);
        exp_t x;
        @(negedge clk);
        b_load = 1'b1; b_lhh = h; b_lmm = m; b_lss = s; b_lpm = pm; b_ena = 1'b1;
        #1 chk({name, ".no_tick"}, 32'(b_tick), 32'd0);
        if (!err) b_cur = to_sec(h, m, s, pm, 1'b1);
        x = from_sec(b_cur, 1'b1);
        x.err = err;
        sb.push_back(x);
        @(negedge clk);
        b_load = 1'b0; b_ena = 1'b0;
        pop_cmp(name, b_hh, b_mm, b_ss, b_pm, b_err);
    endtask

    task automatic b_step(input string name);
        @(negedge clk);
        b_ena = 1'b1;
        #1 chk({name, ".tick"}, 32'(b_tick), 32'd1);
        b_cur = (b_cur + 1) % 86400;
        sb.push_back(from_sec(b_cur, 1'b1));
        @(negedge clk);
        b_ena = 1'b0;
        pop_cmp(name, b_hh, b_mm, b_ss, b_pm, b_err);
    endtask

    task automatic alarm_case(input string name, input logic en, input logic [7:0] mm_l,
                              input logic [7:0] ss_l, input int exp_n, input bit wr_on_tick);
        int n = 0;
        @(negedge clk);
        a_alm_wr = 1'b1; a_alm_hh = 8'h07; a_alm_mm = 8'h30; a_alm_pm = 1'b0; a_alm_en = en;
        a_load = 1'b1; a_lhh = 8'h07; a_lmm = mm_l; a_lss = ss_l; a_ena = 1'b1;
        @(negedge clk);
        a_alm_wr = 1'b0; a_load = 1'b0; a_alm_hh = 8'h08;
        for (int k = 0; k < 10; k++) begin
            n += int'(a_alarm);
            if (wr_on_tick) a_alm_wr = a_tick;
            @(negedge clk);
        end
        a_alm_wr = 1'b0;
        chk(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{8'h12, 8'h34, 8'h56, 1'b0};
        vt[1] = '{8'h12, 8'h34, 8'h5A, 1'b1};
        vt[2] = '{8'h24, 8'h00, 8'h00, 1'b1};
        vt[3] = '{8'h00, 8'h60, 8'h00, 1'b1};
        vt[4] = '{8'h09, 8'h09, 8'h09, 1'b0};
        vt[5] = '{8'h1A, 8'h00, 8'h00, 1'b1};
        vt[6] = '{8'h23, 8'h59, 8'h59, 1'b0};
        vt[7] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vt[8] = '{8'h20, 8'h0F, 8'h00, 1'b1};

        {a_ena, a_load, a_lpm, a_alm_wr, a_alm_pm, a_alm_en} = '0;
        {a_lhh, a_lmm, a_lss, a_alm_hh, a_alm_mm} = '0;
        {b_ena, b_load, b_lpm, b_alm_wr, b_alm_pm, b_alm_en} = '0;
        {b_lhh, b_lmm, b_lss, b_alm_hh, b_alm_mm} = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst24.hh", 32'(a_hh), 32'h23);
        chk("rst24.mm", 32'(a_mm), 32'h59);
        chk("rst24.ss", 32'(a_ss), 32'h45);
        chk("rst24.pm", 32'(a_pm), 32'd0);
        chk("rst24.tick", 32'(a_tick), 32'd0);
        chk("rst12.hh", 32'(b_hh), 32'h11);
        chk("rst12.pm", 32'(b_pm), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        a_cur = to_sec(8'h23, 8'h59, 8'h45, 1'b0, 1'b0);
        b_cur = to_sec(8'h11, 8'h59, 8'h45, 1'b1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a_load = 1'b1; a_lhh = vt[i].hh; a_lmm = vt[i].mm; a_lss = vt[i].ss;
            if (!vt[i].err) a_cur = to_sec(vt[i].hh, vt[i].mm, vt[i].ss, 1'b0, 1'b0);
            e = from_sec(a_cur, 1'b0);
            e.err = vt[i].err;
            sb.push_back(e);
            @(negedge clk);
            a_load = 1'b0;
            pop_cmp($sformatf("load%0d", i), a_hh, a_mm, a_ss, a_pm, a_err);
            @(negedge clk);
            chk($sformatf("load%0d.err_clr", i), 32'(a_err), 32'd0);
        end

        @(negedge clk);
        a_load = 1'b1; a_lhh = 8'h23; a_lmm = 8'h59; a_lss = 8'h58; a_ena = 1'b1;
        a_cur = to_sec(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
        sb.push_back(from_sec(a_cur, 1'b0));
        @(negedge clk);
        a_load = 1'b0;
        pop_cmp("div4.load", a_hh, a_mm, a_ss, a_pm, a_err);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                @(negedge clk);
                if (sb.size() > 0) pop_cmp($sformatf("div4.t%0d", k), a_hh, a_mm, a_ss, a_pm, a_err);
            end
            chk($sformatf("div4.tick%0d", k), 32'(a_tick), 32'(k % 4 == 0));
            if (k % 4 == 0) begin
                a_cur = (a_cur + 1) % 86400;
                sb.push_back(from_sec(a_cur, 1'b0));
            end
        end
        chk("div4.midnight", {8'h0, a_hh, a_mm, a_ss}, 32'h0);

        alarm_case("alm.en1", 1'b1, 8'h29, 8'h59, 1, 1'b0);
        alarm_case("alm.en0", 1'b0, 8'h29, 8'h59, 0, 1'b0);
        alarm_case("alm.direct", 1'b1, 8'h30, 8'h00, 0, 1'b0);
        alarm_case("alm.wr_on_tick", 1'b1, 8'h29, 8'h59, 1, 1'b1);
        a_ena = 1'b0;

        b_do_load("m12.ld1", 8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
        b_step("m12.to12pm");
        b_do_load("m12.ld2", 8'h12, 8'h59, 8'h59, 1'b1, 1'b0);
        b_step("m12.to01pm");
        b_do_load("m12.bad00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        b_do_load("m12.bad13", 8'h13, 8'h00, 8'h00, 1'b0, 1'b1);
        b_do_load("m12.ld3", 8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
        b_step("m12.to12am");

        @(negedge clk);
        a_ena = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.hh", 32'(a_hh), 32'h23);
        chk("arst.mm", 32'(a_mm), 32'h59);
        chk("arst.ss", 32'(a_ss), 32'h45);
        chk("arst.tick", 32'(a_tick), 32'd0);
        chk("arst.alarm", 32'(a_alarm), 32'd0);
        repeat (3) begin
            @(negedge clk);
            a_ena = ~a_ena;
        end
        @(posedge clk);
        #1 chk("arst.hold", 32'(a_ss), 32'h45);
        @(negedge clk);
        a_ena = 1'b1;
        rst_n = 1'b1;
        first_k = -1;
        for (int k = 0; k < 8 && first_k < 0; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (a_tick) first_k = k;
        end
        chk("arst.tick_latency", 32'(first_k), 32'd3);
        @(negedge clk);
        chk("arst.first_adv", 32'(a_ss), 32'h46);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
